rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8_pkg.sv | 19 +
 rtl/rr_arbiter8_if.sv | 14 +
 rtl/rr_arbiter8_dec3to8_en.sv | 15 +
 rtl/rr_arbiter8.sv | 148 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 127 ++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and index helper for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int unsigned NREQ         = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Next round-robin start position; wraps 7 -> 0 through the 3-bit width.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [NREQ-1:0]  req;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt_onehot;
  logic [IDX_W-1:0] ptr;

  modport master (output req, input gnt_valid, gnt_idx, gnt_onehot, ptr);
  modport slave  (input req, output gnt_valid, gnt_idx, gnt_onehot, ptr);

endinterface

// File: rtl/rr_arbiter8_dec3to8_en.sv
// Combinational 3-to-8 decoder with enable; all zeros when disabled.
module dec3to8_en
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [NREQ-1:0]  o_onehot_c
);

  always_comb begin
    o_onehot_c = '0;
    if (i_en) o_onehot_c[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered index/one-hot grant.
// Optional hold timeout: define HOLD_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter8_if.slave bus
);

  if (NREQ != 8 || IDX_W != 3) begin : g_bad_nreq
    $error("rr_arbiter8 supports exactly 8 requesters");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter8 MAX_HOLD must be within 2..256");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_gnt_valid;
  logic             w_valid_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [NREQ-1:0]  r_gnt_onehot;
  logic [NREQ-1:0]  w_onehot_nxt;

  logic [NREQ-1:0]  w_cand_mask;
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_probe;
  logic             w_owner_req;
  logic             w_take;
  logic             w_drop;

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hold_expired;

  assign w_hold_expired = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
`endif

  // The current owner never competes; a releasing owner is already 0 in req.
  assign w_cand_mask = bus.req & ~r_gnt_onehot;
  assign w_owner_req = bus.req[r_gnt_idx];

  // Rotating priority find: scan downward so the lowest offset from r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_probe = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_probe = r_ptr + IDX_W'(i);
      if (w_cand_mask[w_probe]) begin
        w_found = 1'b1;
        w_win   = w_probe;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_gnt_valid;
    w_idx_nxt   = r_gnt_idx;
    w_ptr_nxt   = r_ptr;
    w_take      = 1'b0;
    w_drop      = 1'b0;
`ifdef HOLD_TIMEOUT_EN
    w_cnt_nxt   = r_hold_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        w_take = w_found;
      end
      ST_GRANT: begin
        if (w_owner_req) begin
`ifdef HOLD_TIMEOUT_EN
          if (!w_hold_expired) w_cnt_nxt = r_hold_cnt + CNT_W'(1);
          else if (w_found)    w_take    = 1'b1;
          else                 w_cnt_nxt = '0;
`endif
        end else if (w_found) begin
          w_take = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end
    endcase

    if (w_take) begin
      w_state_nxt = ST_GRANT;
      w_valid_nxt = 1'b1;
      w_idx_nxt   = w_win;
      w_ptr_nxt   = idx_inc(w_win);
`ifdef HOLD_TIMEOUT_EN
      w_cnt_nxt   = '0;
`endif
    end
    if (w_drop) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
      w_idx_nxt   = '0;
`ifdef HOLD_TIMEOUT_EN
      w_cnt_nxt   = '0;
`endif
    end
  end

  // One-hot is decoded from the next index so it registers alongside it.
  dec3to8_en u_dec (
    .i_idx      (w_idx_nxt),
    .i_en       (w_valid_nxt),
    .o_onehot_c (w_onehot_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_ptr        <= '0;
`ifdef HOLD_TIMEOUT_EN
      r_hold_cnt   <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_gnt_valid  <= w_valid_nxt;
      r_gnt_idx    <= w_idx_nxt;
      r_gnt_onehot <= w_onehot_nxt;
      r_ptr        <= w_ptr_nxt;
`ifdef HOLD_TIMEOUT_EN
      r_hold_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.ptr        = r_ptr;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Table-driven bench for rr_arbiter8: each record is one clock of rst/req with the expected registered outputs.
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ev;
    logic [2:0] ei;
    logic [2:0] ep;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic [7:0] q, input logic ev,
                     input logic [2:0] ei, input logic [2:0] ep);
    vec_t v;
    v.rst = r;
    v.req = q;
    v.ev  = ev;
    v.ei  = ei;
    v.ep  = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input int n, input string what, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %h expected %h", n, what, act, exp);
    end
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] exp_oh;
    int         kk;

    rst     = 1'b1;
    bus.req = 8'h00;

    // Reset, then idle with no requests
    add(1'b1, 8'h00, 1'b0, 3'd0, 3'd0);
    add(1'b1, 8'h00, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, 3'd0, 3'd0);

    // Single requester 2 for three cycles, then release
    for (int i = 0; i < 3; i++) add(1'b0, 8'h04, 1'b1, 3'd2, 3'd3);
    for (int i = 0; i < 2; i++) add(1'b0, 8'h00, 1'b0, 3'd0, 3'd3);

    // Grant 5 (ptr -> 6), then wrap: 6 before 0, then 0 after 7
    add(1'b0, 8'h20, 1'b1, 3'd5, 3'd6);
    add(1'b0, 8'h41, 1'b1, 3'd6, 3'd7);
    add(1'b0, 8'h41, 1'b1, 3'd6, 3'd7);
    add(1'b0, 8'h01, 1'b1, 3'd0, 3'd1);
    add(1'b0, 8'h00, 1'b0, 3'd0, 3'd1);

    // All requesting: each owner holds 2 cycles, drops 1 cycle, order 0..7,0
    add(1'b1, 8'hFF, 1'b0, 3'd0, 3'd0);
    add(1'b0, 8'hFF, 1'b1, 3'd0, 3'd1);
    add(1'b0, 8'hFF, 1'b1, 3'd0, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      kk = k % 8;
      m  = 8'hFF & ~(8'h01 << (k - 1));
      add(1'b0, m,     1'b1, 3'(kk), 3'((kk + 1) % 8));
      add(1'b0, 8'hFF, 1'b1, 3'(kk), 3'((kk + 1) % 8));
    end
    add(1'b0, 8'h00, 1'b0, 3'd0, 3'd1);

    // Reset while requester 5 owns the grant
    add(1'b0, 8'h20, 1'b1, 3'd5, 3'd6);
    add(1'b1, 8'h20, 1'b0, 3'd0, 3'd0);
    add(1'b0, 8'h00, 1'b0, 3'd0, 3'd0);
    add(1'b0, 8'h20, 1'b1, 3'd5, 3'd6);
    add(1'b0, 8'h00, 1'b0, 3'd0, 3'd6);

    // Requester 1 owns, requester 3 joins mid-grant
    add(1'b0, 8'h02, 1'b1, 3'd1, 3'd2);
`ifdef HOLD_TIMEOUT_EN
    for (int e = 1; e <= 8; e++) begin
      if (e < 4)       add(1'b0, 8'h0A, 1'b1, 3'd1, 3'd2);
      else if (e < 8)  add(1'b0, 8'h0A, 1'b1, 3'd3, 3'd4);
      else             add(1'b0, 8'h0A, 1'b1, 3'd1, 3'd2);
    end
`else
    for (int e = 0; e < 8; e++) add(1'b0, 8'h0A, 1'b1, 3'd1, 3'd2);
`endif
    // Lone owner keeps the grant indefinitely
    for (int e = 0; e < 8; e++) add(1'b0, 8'h02, 1'b1, 3'd1, 3'd2);
    add(1'b0, 8'h00, 1'b0, 3'd0, 3'd2);

    foreach (vecs[n]) begin
      @(negedge clk);
      rst     = vecs[n].rst;
      bus.req = vecs[n].req;
      @(posedge clk);
      #1;
      exp_oh = vecs[n].ev ? (8'h01 << vecs[n].ei) : 8'h00;
      check(n, "gnt_valid",  8'(bus.gnt_valid),  8'(vecs[n].ev));
      check(n, "gnt_idx",    8'(bus.gnt_idx),    8'(vecs[n].ei));
      check(n, "gnt_onehot", bus.gnt_onehot,     exp_oh);
      check(n, "ptr",        8'(bus.ptr),        8'(vecs[n].ep));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
